// File: rtl/rst_seq.sv
// Sequenced per-channel reset release after clock lock; optional LOCK input under `RST_SEQ_LOCK_EN.
// Channel 0 releases 3+HOLD_CYC edges after RSTn release, then one channel per STAGE_CYC; no backpressure.
module rst_seq #(
    parameter int NCH       = 4,
    parameter int HOLD_CYC  = 32768,
    parameter int STAGE_CYC = 16
) (
    input  logic           CLK,
    input  logic           RSTn,
`ifdef RST_SEQ_LOCK_EN
    input  logic           LOCK,
`endif
    input  logic           SW_RST,
    output logic [NCH-1:0] RST_OUTn,
    output logic           READY
);

    localparam int HW = (HOLD_CYC  > 1) ? $clog2(HOLD_CYC)  : 1;
    localparam int SW = (STAGE_CYC > 1) ? $clog2(STAGE_CYC) : 1;
    localparam int IW = (NCH       > 1) ? $clog2(NCH)       : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
    localparam logic [SW-1:0] STG_LAST  = SW'(STAGE_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NCH - 1);

    typedef enum logic [1:0] {IDLE, HOLD, STAGE, RUN} state_t;

    state_t          state, state_d;
    logic [HW-1:0]   hold_cnt, hold_d;
    logic [SW-1:0]   stg_cnt, stg_d;
    logic [IW-1:0]   idx, idx_d;
    logic [NCH-1:0]  rst_out_d;
    logic            ready_d;
    logic            rst_s1, rst_s;
    logic            lock_s;
    logic            abort;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            rst_s1 <= 1'b0;
            rst_s  <= 1'b0;
        end else begin
            rst_s1 <= 1'b1;
            rst_s  <= rst_s1;
        end
    end

`ifdef RST_SEQ_LOCK_EN
    logic lock_s1;
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            lock_s1 <= 1'b0;
            lock_s  <= 1'b0;
        end else begin
            lock_s1 <= LOCK;
            lock_s  <= lock_s1;
        end
    end
`else
    assign lock_s = 1'b1;
`endif

    assign abort = !lock_s || SW_RST;

    // Outputs are registered from the next state so released channels never see decode glitches.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state    <= IDLE;
            hold_cnt <= '0;
            stg_cnt  <= '0;
            idx      <= '0;
            RST_OUTn <= '0;
            READY    <= 1'b0;
        end else if (!rst_s) begin
            state    <= IDLE;
            hold_cnt <= '0;
            stg_cnt  <= '0;
            idx      <= '0;
            RST_OUTn <= '0;
            READY    <= 1'b0;
        end else begin
            state    <= state_d;
            hold_cnt <= hold_d;
            stg_cnt  <= stg_d;
            idx      <= idx_d;
            RST_OUTn <= rst_out_d;
            READY    <= ready_d;
        end
    end

    always_comb begin
        state_d = state;
        hold_d  = hold_cnt;
        stg_d   = stg_cnt;
        idx_d   = idx;
        if (state != IDLE && abort) begin
            state_d = IDLE;
            hold_d  = '0;
            stg_d   = '0;
            idx_d   = '0;
        end else begin
            case (state)
                IDLE: begin
                    hold_d = '0;
                    stg_d  = '0;
                    idx_d  = '0;
                    if (lock_s && !SW_RST) state_d = HOLD;
                end
                HOLD: begin
                    if (hold_cnt == HOLD_LAST) state_d = STAGE;
                    else                       hold_d  = hold_cnt + 1'b1;
                end
                STAGE: begin
                    if (idx == IDX_LAST) begin
                        state_d = RUN;
                    end else if (stg_cnt == STG_LAST) begin
                        stg_d = '0;
                        idx_d = idx + 1'b1;
                    end else begin
                        stg_d = stg_cnt + 1'b1;
                    end
                end
                RUN: ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        rst_out_d = '0;
        ready_d   = 1'b0;
        case (state_d)
            STAGE: begin
                for (int k = 0; k < NCH; k++) rst_out_d[k] = (k <= int'(idx_d));
            end
            RUN: begin
                rst_out_d = '1;
                ready_d   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/rst_seq.md
RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 Parameter NCH, default 4: number of sequenced reset channels, 1..16.
REQ-002 Parameter HOLD_CYC, default 32768: CLK cycles all channels stay asserted after clock lock before first release, >=1.
REQ-003 Parameter STAGE_CYC, default 16: CLK cycles between release of channel k and channel k+1, >=1.
REQ-004 CLK  in  1  system clock.
REQ-005 RSTn  in  1  reset, asynchronous, active-low.
REQ-006 LOCK  in  1  PLL lock, asynchronous to CLK (present only with RST_SEQ_LOCK_EN).
REQ-007 SW_RST  in  1  synchronous soft-reset request, active-high, level or pulse.
REQ-008 RST_OUTn  out  NCH  per-channel reset, active-low; bit k is released after bit k-1.
REQ-009 READY  out  1  high when all channels are released and sequencing is complete.

Function
REQ-010 RSTn and LOCK SHALL each pass through a 2-flop synchronizer; both synchronizers clear asynchronously on RSTn low. Outputs: rst_s, lock_s.
REQ-011 FSM states SHALL be IDLE, HOLD, STAGE, RUN; all logic other than the rst_s synchronizer SHALL be held in IDLE while rst_s=0.
REQ-012 IDLE: RST_OUTn=all 0, READY=0; -> HOLD when lock_s=1 and SW_RST=0; hold counter cleared.
REQ-013 HOLD: hold counter increments each cycle; on the cycle it equals HOLD_CYC-1 -> STAGE, and RST_OUTn[0] SHALL go 1 at that same edge.
REQ-014 STAGE: stage counter counts 0..STAGE_CYC-1; at each wrap the next channel is released; after channel NCH-1 is released -> RUN at the following edge.
REQ-015 NCH=1: STAGE SHALL last exactly 1 cycle; READY rises 1 cycle after RST_OUTn[0].
REQ-016 RUN: READY=1, RST_OUTn=all 1, counters frozen.
REQ-017 From HOLD, STAGE or RUN, lock_s=0 or SW_RST=1 SHALL force IDLE at the next edge, with RST_OUTn=all 0 and READY=0 at that edge and all counters cleared. Released channels are re-asserted together; there is no reverse sequencing.
REQ-018 SW_RST=1 in IDLE SHALL keep the FSM in IDLE. SW_RST and lock-loss together SHALL behave as a single abort.
REQ-019 Counter widths SHALL be $clog2 of the respective parameter (minimum 1). Counters SHALL never wrap in HOLD; compare is exact equality.
REQ-020 A released channel SHALL never glitch low except via REQ-017 or reset. Once released, RST_OUTn bits stay monotonic until abort.
REQ-021 Latency: with LOCK stable high and SW_RST=0, RST_OUTn[0] SHALL rise exactly 3+HOLD_CYC edges after the first edge sampling RSTn=1. RST_OUTn[k] SHALL rise k*STAGE_CYC edges later. READY SHALL rise 1 edge after RST_OUTn[NCH-1].

Reset
REQ-022 RSTn low SHALL asynchronously force the following, regardless of CLK: RST_OUTn=all 0, READY=0, state IDLE, counters 0, synchronizers 0.
REQ-023 RSTn low mid-HOLD or mid-STAGE SHALL restart the full sequence from REQ-021 after release.
REQ-024 Deassertion of RSTn SHALL take effect only via the synchronizer; no output changes combinationally on RSTn rising.

Configuration
REQ-025 Macro RST_SEQ_LOCK_EN defined: LOCK port exists, is synchronized, and gates IDLE->HOLD and causes abort per REQ-017.
REQ-026 Macro RST_SEQ_LOCK_EN undefined: LOCK port absent and lock_s is constant 1. Only SW_RST and RSTn abort; REQ-021 latency is unchanged.

Verification (NCH=3, HOLD_CYC=8, STAGE_CYC=4, LOCK_EN defined unless noted)
REQ-027 Power-up: RSTn 0->1, LOCK=1 -> RST_OUTn[0] rises at edge 11, [1] at 15, [2] at 19, READY at 20.
REQ-028 Lock gating: LOCK=0 for 50 cycles after RSTn release, then 1 -> RST_OUTn stays 000 until lock_s high; RST_OUTn[0] rises 1+8 edges after lock_s rises.
REQ-029 Abort mid-STAGE: SW_RST 1-cycle pulse while RST_OUTn=001 -> next edge RST_OUTn=000, READY=0; full sequence re-runs with the same 8/4/4 spacing.
REQ-030 Lock loss in RUN: LOCK drops -> RST_OUTn=000 and READY=0 exactly 3 edges after LOCK falls; LOCK return re-sequences.
REQ-031 Async reset: RSTn low mid-HOLD, between clock edges -> RST_OUTn=000 and READY=0 immediately with no CLK; release repeats REQ-027 timing.
REQ-032 Macro undefined, NCH=1: RSTn release -> RST_OUTn[0] at edge 11, READY at edge 12; SW_RST held high keeps outputs 0.
